dsp_bus_qualifier: RTL
======================

# dsp_bus_qualifier

- Front-end stage between the asynchronous 16-bit DSP bus pins and the application blocks (test apps, etc.) in the FPGA.
- Synchronises and glitch-filters the DSP strobes, and latches address and write data.
- Issues single-cycle `write_qualified` and `read_qualified` pulses with stable `ab` and `db_in`.
- Captures the registered application read response and drives it back onto the bidirectional data bus for the rest of the read strobe.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser depth on `cs_n`, `rd_n`, `we_n` (min 2).
- `FILTER_CYCLES`, 2: consecutive synchronised-active cycles required to accept a strobe (min 1).
- `TIMEOUT_CYCLES`, 1024: strobe hold limit. Used only with `DSP_BUS_TIMEOUT_EN`.

Ports:
- `xclk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `cs_n`, `rd_n`, `we_n`, in, 1 each: asynchronous DSP chip-select, read and write strobes, active low.
- `ab_pin`, in, 8: asynchronous DSP address.
- `db_pin_in`, in, 16: data bus input buffer.
- `db_pin_out`, out, 16: data bus output value.
- `db_pin_oe`, out, 1: output-buffer enable, active high.
- `ab`, out, 8: latched address, held until the next qualification.
- `db_in`, out, 16: latched write data.
- `write_qualified`, `read_qualified`, out, 1 each: one-cycle pulses.
- `db_out_app`, in, 16: merged application read data.
- `data_avail_app`, in, 1: merged application "address claimed" flag.
- `bus_error`, out, 1: one-cycle pulse when both strobes are active together.
- `timeout_flag`, out, 1: sticky flag, present only with `DSP_BUS_TIMEOUT_EN`.

## Operation
- Active strobe = synchronised `cs_n` low AND synchronised `rd_n` or `we_n` low.
- Armed bit: cleared by reset. Set once synchronised `rd_n` and `we_n` have both been high for 1 cycle. No strobe is accepted while disarmed, so a strobe already low out of reset is ignored.
- States: IDLE, FILT, WR_HOLD, RD_WAIT, RD_DRIVE.
  - IDLE -> FILT: armed and a strobe is active; clear the filter counter.
  - FILT: increment while the same strobe stays active; return to IDLE on any deassertion.
    - At count `FILTER_CYCLES`: latch `ab_pin` into `ab`.
    - For a write, also latch `db_pin_in` into `db_in`, pulse `write_qualified` and go to WR_HOLD.
    - For a read, pulse `read_qualified` and go to RD_WAIT.
  - WR_HOLD: wait for `we_n` or `cs_n` to deassert (synchronised), then go to IDLE.
  - RD_WAIT: one cycle.
    - If `data_avail_app`=1: capture `db_out_app` into `db_pin_out` and go to RD_DRIVE.
    - Else: go to RD_DRIVE with `db_pin_oe` kept 0 (unclaimed address floats).
  - RD_DRIVE: hold `db_pin_oe` (1 if claimed) until `rd_n` or `cs_n` deasserts (synchronised). `db_pin_oe` drops in the same cycle the deassertion is seen; go to IDLE.
- Both `rd_n` and `we_n` active in IDLE or FILT: pulse `bus_error`, return to IDLE, and stay there until both strobes are seen high.
- Exactly one qualification per strobe assertion; no re-qualification while a strobe is held.
- Reset values: all state IDLE, armed 0. Outputs `ab`=0, `db_in`=0, `db_pin_out`=0, `db_pin_oe`=0, all pulses 0, `timeout_flag`=0.

## Timing
- A strobe first sampled low at edge k makes the qualified pulse high in cycle k+`SYNC_STAGES`+`FILTER_CYCLES`. With defaults, that is 4 cycles after first sample.
- The qualified pulse lasts exactly 1 cycle.
- `ab` and `db_in` become valid in the same cycle as the pulse and stay stable until the next qualification.
- `db_out_app` and `data_avail_app` are sampled exactly 1 cycle after `read_qualified`. Applications register their response on the qualified edge.
- `db_pin_oe` rises 2 cycles after `read_qualified` at the earliest.
- `db_pin_oe` falls `SYNC_STAGES`+1 cycles after `rd_n` rises at the pin.
- Reset asserted mid-read: `db_pin_oe` = 0 at the next edge.

## Configuration
- Macro: `DSP_BUS_TIMEOUT_EN`.
- Defined:
  - A counter runs in WR_HOLD and RD_DRIVE.
  - At `TIMEOUT_CYCLES`: force `db_pin_oe`=0, set `timeout_flag` (cleared only by reset), go to IDLE with armed=0.
- Undefined: no counter and no `timeout_flag` port; WR_HOLD and RD_DRIVE wait indefinitely.

## Structure
- Shared package/include: state encoding constants, reset value 16'h0000, and the minimum-parameter checks.
- One sub-module `sync_filter` (per-bit synchroniser with `SYNC_STAGES` flops), instantiated three times, for `cs_n`, `rd_n` and `we_n`.

## Test plan
- Write: `ab_pin`=8'h12, `db_pin_in`=16'hA5A5, `we_n` low 10 cycles -> single `write_qualified` at cycle 4, `ab`=8'h12, `db_in`=16'hA5A5.
- Read claimed: `ab_pin`=8'h20, app returns 16'h5A5A with avail=1 -> `read_qualified` once, `db_pin_oe`=1 with 16'h5A5A until 3 cycles after `rd_n` rises.
- Read unclaimed: `data_avail_app`=0 -> `db_pin_oe` remains 0 throughout.
- Glitch: `we_n` low for 1 cycle -> no pulse. Both strobes low -> `bus_error` pulse, no qualification.
- Reset released with `rd_n` already low -> no `read_qualified` until `rd_n` goes high, then low again.
- With `DSP_BUS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, `rd_n` held low -> `db_pin_oe` drops and `timeout_flag`=1 after 16 RD_DRIVE cycles.

Source files
------------

// File: rtl/dsp_bus_qualifier_pkg.sv
// dsp_bus_qualifier_pkg
//   Shared definitions for the DSP bus front end:
//   - bus widths and the data/address reset values
//   - front-end FSM state encoding
//   - minimum-parameter check used at elaboration of the top
//   Optional feature macro handled by the top: DSP_BUS_TIMEOUT_EN.
package dsp_bus_qualifier_pkg;

  localparam int AB_W = 8;
  localparam int DB_W = 16;

  localparam logic [DB_W-1:0] DB_RESET = 16'h0000;
  localparam logic [AB_W-1:0] AB_RESET = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILT     = 3'd1,
    ST_WR_HOLD  = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RD_DRIVE = 3'd4
  } state_t;

  // Two flops is the least that gives the async strobes a resolution cycle;
  // the filter needs at least one qualifying cycle; the timeout at least one.
  function automatic bit params_ok(input int sync_stages,
                                   input int filter_cycles,
                                   input int timeout_cycles);
    return (sync_stages >= 2) && (filter_cycles >= 1) && (timeout_cycles >= 1);
  endfunction

endpackage

// File: rtl/dsp_bus_qualifier_if.sv
// dsp_bus_qualifier_if
//   Groups the DSP pin-side signals and the application-side qualified bus.
//   master : the qualifier (samples pins and app response, drives qualified bus)
//   slave  : pin buffers plus the application blocks
//   Pin side : cs_n, rd_n, we_n, ab_pin, db_pin_in, db_pin_out, db_pin_oe
//   App side : ab, db_in, write_qualified, read_qualified,
//              db_out_app, data_avail_app, bus_error
interface dsp_bus_qualifier_if;
  import dsp_bus_qualifier_pkg::*;

  logic            cs_n;
  logic            rd_n;
  logic            we_n;
  logic [AB_W-1:0] ab_pin;
  logic [DB_W-1:0] db_pin_in;
  logic [DB_W-1:0] db_pin_out;
  logic            db_pin_oe;
  logic [AB_W-1:0] ab;
  logic [DB_W-1:0] db_in;
  logic            write_qualified;
  logic            read_qualified;
  logic [DB_W-1:0] db_out_app;
  logic            data_avail_app;
  logic            bus_error;

  modport master (
    input  cs_n, rd_n, we_n, ab_pin, db_pin_in, db_out_app, data_avail_app,
    output db_pin_out, db_pin_oe, ab, db_in, write_qualified, read_qualified,
           bus_error
  );

  modport slave (
    output cs_n, rd_n, we_n, ab_pin, db_pin_in, db_out_app, data_avail_app,
    input  db_pin_out, db_pin_oe, ab, db_in, write_qualified, read_qualified,
           bus_error
  );

endinterface

// File: rtl/dsp_bus_qualifier_sync_filter.sv
// sync_filter
//   Single-bit synchroniser for an asynchronous DSP strobe.
//   Ports: xclk (clock), reset (sync, active high), d (async input),
//          q (synchronised output, SYNC_STAGES cycles of latency).
//   RST_VAL is the value the chain holds in reset.
module sync_filter #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic xclk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_p;

  always_ff @(posedge xclk) begin
    if (reset) begin
      sync_p <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/dsp_bus_qualifier.sv
// dsp_bus_qualifier
//   Front end between the asynchronous 16-bit DSP bus and the application
//   blocks. Synchronises and glitch-filters cs_n/rd_n/we_n, latches address
//   and write data, issues one-cycle write_qualified / read_qualified pulses,
//   and drives the registered application read response back onto the data
//   bus for the remainder of the read strobe.
//   Ports:
//     xclk, reset     : clock, synchronous active-high reset
//     bus (master)    : pin side and application side, see dsp_bus_qualifier_if
//     timeout_flag    : sticky strobe-hold timeout (only with DSP_BUS_TIMEOUT_EN)
//   Optional feature macro: DSP_BUS_TIMEOUT_EN (strobe hold timeout).
module dsp_bus_qualifier
  import dsp_bus_qualifier_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       xclk,
  input  logic                       reset,
  dsp_bus_qualifier_if.master        bus
`ifdef DSP_BUS_TIMEOUT_EN
  ,
  output logic                       timeout_flag
`endif
);

  generate
    if (!params_ok(SYNC_STAGES, FILTER_CYCLES, TIMEOUT_CYCLES)) begin : g_param_check
      $error("dsp_bus_qualifier: need SYNC_STAGES>=2, FILTER_CYCLES>=1, TIMEOUT_CYCLES>=1");
    end
  endgenerate

  localparam int                FCNT_W    = $clog2(FILTER_CYCLES + 1);
  localparam logic [FCNT_W-1:0] FILT_LAST = FCNT_W'(FILTER_CYCLES - 1);

  // Synchronised strobes (active low). The chains reset to 0 so that the
  // strobes look asserted until real highs have crossed the synchroniser;
  // this keeps the armed bit clear until the pins are genuinely idle.
  logic cs_s;
  logic rd_s;
  logic we_s;

  sync_filter #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
    .xclk(xclk), .reset(reset), .d(bus.cs_n), .q(cs_s)
  );
  sync_filter #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_rd (
    .xclk(xclk), .reset(reset), .d(bus.rd_n), .q(rd_s)
  );
  sync_filter #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_we (
    .xclk(xclk), .reset(reset), .d(bus.we_n), .q(we_s)
  );

  logic rd_act;
  logic wr_act;
  logic both_act;

  assign rd_act   = ~cs_s & ~rd_s;
  assign wr_act   = ~cs_s & ~we_s;
  assign both_act = rd_act & wr_act;

  state_t            state,   state_nxt;
  logic [FCNT_W-1:0] fcnt,    fcnt_nxt;
  logic              is_wr,   is_wr_nxt;
  logic              armed,   armed_nxt;
  logic [AB_W-1:0]   ab_q,    ab_nxt;
  logic [DB_W-1:0]   db_in_q, db_in_nxt;
  logic [DB_W-1:0]   dout_q,  dout_nxt;
  logic              oe_q,    oe_nxt;
  logic              wq_q,    wq_nxt;
  logic              rq_q,    rq_nxt;
  logic              err_q,   err_nxt;

`ifdef DSP_BUS_TIMEOUT_EN
  localparam int                TCNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCNT_W-1:0] TO_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  logic [TCNT_W-1:0] to_cnt, to_cnt_nxt;
  logic              to_flag, to_flag_nxt;
`endif

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    is_wr_nxt = is_wr;
    // Arm once both synchronised strobes have been seen high.
    armed_nxt = armed | (rd_s & we_s);
    ab_nxt    = ab_q;
    db_in_nxt = db_in_q;
    dout_nxt  = dout_q;
    oe_nxt    = oe_q;
    wq_nxt    = 1'b0;
    rq_nxt    = 1'b0;
    err_nxt   = 1'b0;
`ifdef DSP_BUS_TIMEOUT_EN
    to_cnt_nxt  = '0;
    to_flag_nxt = to_flag;
`endif

    case (state)
      ST_IDLE: begin
        oe_nxt = 1'b0;
        // Disarming on an error holds us here until both strobes go high.
        if (armed && both_act) begin
          err_nxt   = 1'b1;
          armed_nxt = 1'b0;
        end else if (armed && (rd_act || wr_act)) begin
          state_nxt = ST_FILT;
          fcnt_nxt  = '0;
          is_wr_nxt = wr_act;
        end
      end

      ST_FILT: begin
        if (both_act) begin
          err_nxt   = 1'b1;
          armed_nxt = 1'b0;
          state_nxt = ST_IDLE;
        end else if (is_wr ? wr_act : rd_act) begin
          if (fcnt == FILT_LAST) begin
            ab_nxt = bus.ab_pin;
            if (is_wr) begin
              db_in_nxt = bus.db_pin_in;
              wq_nxt    = 1'b1;
              state_nxt = ST_WR_HOLD;
            end else begin
              rq_nxt    = 1'b1;
              state_nxt = ST_RD_WAIT;
            end
          end else begin
            fcnt_nxt = fcnt + FCNT_W'(1);
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end

      ST_WR_HOLD: begin
        if (!wr_act) begin
          state_nxt = ST_IDLE;
        end
      end

      ST_RD_WAIT: begin
        // The app registers its response on the edge that sees the pulse,
        // so sample it on the cycle after the pulse has dropped.
        if (!rq_q) begin
          if (!rd_act) begin
            state_nxt = ST_IDLE;
          end else begin
            if (bus.data_avail_app) begin
              dout_nxt = bus.db_out_app;
              oe_nxt   = 1'b1;
            end
            state_nxt = ST_RD_DRIVE;
          end
        end
      end

      ST_RD_DRIVE: begin
        if (!rd_act) begin
          oe_nxt    = 1'b0;
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        oe_nxt    = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase

`ifdef DSP_BUS_TIMEOUT_EN
    // Counts only while remaining in a hold state; entry restarts at 0.
    if (((state == ST_WR_HOLD) || (state == ST_RD_DRIVE)) && (state_nxt == state)) begin
      if (to_cnt == TO_LAST) begin
        oe_nxt      = 1'b0;
        to_flag_nxt = 1'b1;
        armed_nxt   = 1'b0;
        state_nxt   = ST_IDLE;
      end else begin
        to_cnt_nxt = to_cnt + TCNT_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge xclk) begin
    if (reset) begin
      state   <= ST_IDLE;
      fcnt    <= '0;
      is_wr   <= 1'b0;
      armed   <= 1'b0;
      ab_q    <= AB_RESET;
      db_in_q <= DB_RESET;
      dout_q  <= DB_RESET;
      oe_q    <= 1'b0;
      wq_q    <= 1'b0;
      rq_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef DSP_BUS_TIMEOUT_EN
      to_cnt  <= '0;
      to_flag <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      fcnt    <= fcnt_nxt;
      is_wr   <= is_wr_nxt;
      armed   <= armed_nxt;
      ab_q    <= ab_nxt;
      db_in_q <= db_in_nxt;
      dout_q  <= dout_nxt;
      oe_q    <= oe_nxt;
      wq_q    <= wq_nxt;
      rq_q    <= rq_nxt;
      err_q   <= err_nxt;
`ifdef DSP_BUS_TIMEOUT_EN
      to_cnt  <= to_cnt_nxt;
      to_flag <= to_flag_nxt;
`endif
    end
  end

  assign bus.ab              = ab_q;
  assign bus.db_in           = db_in_q;
  assign bus.db_pin_out      = dout_q;
  assign bus.db_pin_oe       = oe_q;
  assign bus.write_qualified = wq_q;
  assign bus.read_qualified  = rq_q;
  assign bus.bus_error       = err_q;
`ifdef DSP_BUS_TIMEOUT_EN
  assign timeout_flag        = to_flag;
`endif

endmodule
